// File: rtl/uvmt_st_clknrst_chk.sv
// ----------------------------------------------------------------------------
// uvmt_st_clknrst_chk
//
// Consumer-side checker for the self-test clock/reset generator. It turns the
// generator's block reset into a synchronised, stretched downstream reset for
// the VIP interfaces, checks that reset_n_obs is the complement of reset,
// counts cycles spent in RUN and runs a heartbeat watchdog that pulls the
// downstream reset low again if the heartbeat stops.
//
// Ports:
//   clk          free-running clock
//   reset        asynchronous active-high block reset
//   reset_n_obs  generator's active-low reset, polarity-checked
//   heartbeat    watchdog kick, sampled on rising clk
//   wdog_en      watchdog enable
//   rst_sync_n   downstream reset: asserts asynchronously, releases on clk
//   rst_done     one-cycle pulse on entry to RUN
//   running      high while in RUN
//   cycle_cnt    edges elapsed in RUN, saturating, frozen in FAULT
//   polarity_err sticky: reset_n_obs seen low while out of reset
//   wdog_fault   sticky: watchdog expired
//   state        SYNC=0, STRETCH=1, RUN=2, FAULT=3
// ----------------------------------------------------------------------------
module uvmt_st_clknrst_chk #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH_CYC = 4,
  parameter int unsigned WDOG_CYC    = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reset_n_obs,
  input  logic             heartbeat,
  input  logic             wdog_en,
  output logic             rst_sync_n,
  output logic             rst_done,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             polarity_err,
  output logic             wdog_fault,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StSync    = 2'd0,
    StStretch = 2'd1,
    StRun     = 2'd2,
    StFault   = 2'd3
  } state_e;

  localparam int unsigned StrW = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;
  localparam int unsigned WdW  = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

  // Terminal counts; the stretch one is unused when STRETCH_CYC is zero.
  localparam logic [StrW-1:0] StrLast = (STRETCH_CYC > 0) ? StrW'(STRETCH_CYC - 1) : '0;
  localparam logic [WdW-1:0]  WdLast  = WdW'(WDOG_CYC - 1);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [StrW-1:0]        str_cnt_q;
  logic [WdW-1:0]         wd_cnt_q;
  logic [CNT_W-1:0]       cycle_cnt_q;
  logic                   rst_sync_n_q;
  logic                   rst_done_q;
  logic                   running_q;
  logic                   polarity_err_q;
  logic                   wdog_fault_q;

  logic sync_last;
  logic str_last;
  logic wd_last;
  logic cnt_max;

  always_comb begin
    // The MSB of the shift register rises on this edge.
    sync_last = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    str_last  = (str_cnt_q == StrLast);
    wd_last   = (wd_cnt_q == WdLast);
    cnt_max   = &cycle_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StSync;
      sync_q         <= '0;
      str_cnt_q      <= '0;
      wd_cnt_q       <= '0;
      cycle_cnt_q    <= '0;
      rst_sync_n_q   <= 1'b0;
      rst_done_q     <= 1'b0;
      running_q      <= 1'b0;
      polarity_err_q <= 1'b0;
      wdog_fault_q   <= 1'b0;
    end else begin
      rst_done_q <= 1'b0;

      // Polarity is only meaningful once the block reset has gone away; FAULT
      // is excluded because the downstream side is already held in reset.
      if ((state_q != StFault) && !reset_n_obs) begin
        polarity_err_q <= 1'b1;
      end

      unique case (state_q)
        StSync: begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
          if (sync_last) begin
            str_cnt_q <= '0;
            if (STRETCH_CYC == 0) begin
              state_q      <= StRun;
              rst_sync_n_q <= 1'b1;
              running_q    <= 1'b1;
              rst_done_q   <= 1'b1;
              cycle_cnt_q  <= '0;
              wd_cnt_q     <= '0;
            end else begin
              state_q <= StStretch;
            end
          end
        end

        StStretch: begin
          if (str_last) begin
            state_q      <= StRun;
            rst_sync_n_q <= 1'b1;
            running_q    <= 1'b1;
            rst_done_q   <= 1'b1;
            cycle_cnt_q  <= '0;
            wd_cnt_q     <= '0;
          end else begin
            str_cnt_q <= str_cnt_q + StrW'(1);
          end
        end

        StRun: begin
          // The edge that trips the watchdog still counts as a RUN edge.
          if (!cnt_max) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
          end
          if (!wdog_en || heartbeat) begin
            // A heartbeat on the terminal edge wins over the timeout.
            wd_cnt_q <= '0;
          end else if (wd_last) begin
            state_q      <= StFault;
            wdog_fault_q <= 1'b1;
            rst_sync_n_q <= 1'b0;
            running_q    <= 1'b0;
          end else begin
            wd_cnt_q <= wd_cnt_q + WdW'(1);
          end
        end

        StFault: begin
          // Sticky until the block reset; heartbeat and wdog_en are ignored.
        end
      endcase
    end
  end

  assign rst_sync_n   = rst_sync_n_q;
  assign rst_done     = rst_done_q;
  assign running      = running_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign polarity_err = polarity_err_q;
  assign wdog_fault   = wdog_fault_q;
  assign state        = state_q;

endmodule

// File: tb/tb_uvmt_st_clknrst_chk.sv
// ----------------------------------------------------------------------------
// Bench for uvmt_st_clknrst_chk. Two instances share the stimulus: "a" uses
// the default parameters, "b" uses STRETCH_CYC=0 and CNT_W=4 with its
// watchdog disabled. A model counts edges since reset release and consecutive
// quiet watchdog edges and derives every output from those counts.
// ----------------------------------------------------------------------------
module tb_uvmt_st_clknrst_chk;

  localparam int SS   = 2;
  localparam int WDOG = 16;

  logic        clk;
  logic        reset;
  logic        reset_n_obs;
  logic        heartbeat;
  logic        wdog_en;
  logic        wdog_en_b;

  logic        rsn_a, done_a, run_a, pe_a, wf_a;
  logic [31:0] cnt_a;
  logic [1:0]  st_a;
  logic        rsn_b, done_b, run_b, pe_b, wf_b;
  logic [3:0]  cnt_b;
  logic [1:0]  st_b;

  uvmt_st_clknrst_chk dut_a (
    .clk          (clk),
    .reset        (reset),
    .reset_n_obs  (reset_n_obs),
    .heartbeat    (heartbeat),
    .wdog_en      (wdog_en),
    .rst_sync_n   (rsn_a),
    .rst_done     (done_a),
    .running      (run_a),
    .cycle_cnt    (cnt_a),
    .polarity_err (pe_a),
    .wdog_fault   (wf_a),
    .state        (st_a)
  );

  uvmt_st_clknrst_chk #(
    .STRETCH_CYC (0),
    .CNT_W       (4)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .reset_n_obs  (reset_n_obs),
    .heartbeat    (heartbeat),
    .wdog_en      (wdog_en_b),
    .rst_sync_n   (rsn_b),
    .rst_done     (done_b),
    .running      (run_b),
    .cycle_cnt    (cnt_b),
    .polarity_err (pe_b),
    .wdog_fault   (wf_b),
    .state        (st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int     stretch_c [2] = '{4, 0};
  int     cntw_c    [2] = '{32, 4};
  longint rel       [2];
  longint frozen    [2];
  bit     faulted   [2];
  bit     pol       [2];
  int     quiet     [2];

  function automatic longint sat(input int i, input longint v);
    longint mx;
    mx = (longint'(1) << cntw_c[i]) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input int i, input logic r, input logic obs, input logic hb,
                            input logic en);
    longint re;
    re = SS + stretch_c[i];
    if (r) begin
      rel[i] = 0; frozen[i] = 0; faulted[i] = 0; pol[i] = 0; quiet[i] = 0;
    end else if (!faulted[i]) begin
      if (!obs) pol[i] = 1;
      if (rel[i] >= re) begin
        if (!en || hb) quiet[i] = 0;
        else begin
          quiet[i]++;
          if (quiet[i] == WDOG) begin
            faulted[i] = 1;
            frozen[i]  = sat(i, rel[i] + 1 - re);
          end
        end
      end
      rel[i]++;
    end
  endtask

  task automatic compare(input int i, input logic [1:0] st, input logic rsn, input logic done,
                         input logic run, input logic [63:0] cnt, input logic pe,
                         input logic wf);
    longint re;
    logic [1:0]  e_st;
    logic        e_rsn, e_done, e_run, e_wf;
    logic [63:0] e_cnt;
    string nm;
    nm = (i == 0) ? "a" : "b";
    re = SS + stretch_c[i];
    if (faulted[i]) begin
      e_st = 2'd3; e_rsn = 0; e_done = 0; e_run = 0; e_cnt = frozen[i]; e_wf = 1;
    end else if (rel[i] < SS) begin
      e_st = 2'd0; e_rsn = 0; e_done = 0; e_run = 0; e_cnt = 0; e_wf = 0;
    end else if (rel[i] < re) begin
      e_st = 2'd1; e_rsn = 0; e_done = 0; e_run = 0; e_cnt = 0; e_wf = 0;
    end else begin
      e_st = 2'd2; e_rsn = 1; e_done = (rel[i] == re); e_run = 1;
      e_cnt = sat(i, rel[i] - re); e_wf = 0;
    end
    check({nm, ".state"}, st, e_st);
    check({nm, ".rst_sync_n"}, rsn, e_rsn);
    check({nm, ".rst_done"}, done, e_done);
    check({nm, ".running"}, run, e_run);
    check({nm, ".cycle_cnt"}, cnt, e_cnt);
    check({nm, ".polarity_err"}, pe, pol[i]);
    check({nm, ".wdog_fault"}, wf, e_wf);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rel[i] = 0; frozen[i] = 0; faulted[i] = 0; pol[i] = 0; quiet[i] = 0;
    end
    forever begin
      @(posedge clk);
      model_step(0, reset, reset_n_obs, heartbeat, wdog_en);
      model_step(1, reset, reset_n_obs, heartbeat, wdog_en_b);
      #1;
      compare(0, st_a, rsn_a, done_a, run_a, 64'(cnt_a), pe_a, wf_a);
      compare(1, st_b, rsn_b, done_b, run_b, 64'(cnt_b), pe_b, wf_b);
    end
  end

  // ---------------- stimulus ----------------
  bit hb_auto;
  bit hb_man;
  int hb_phase;

  // Inputs set before a tick apply to the next rising edge; returns just
  // after the n-th falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      heartbeat = hb_auto ? ((hb_phase % 4) == 3) : hb_man;
      hb_phase++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reset_n_obs = 1'b0;
    tick(2);
  endtask

  task automatic rel_reset();
    reset = 1'b0;
    reset_n_obs = 1'b1;
    hb_phase = 0;
  endtask

  initial begin
    reset = 1'b1; reset_n_obs = 1'b0; heartbeat = 1'b0;
    wdog_en = 1'b0; wdog_en_b = 1'b0;
    hb_auto = 0; hb_man = 0; hb_phase = 0;
    tick(3);
    check("rst.state", st_a, 0);
    check("rst.rst_sync_n", rsn_a, 0);
    check("rst.cycle_cnt", cnt_a, 0);

    // 1: release sequence with a regular heartbeat
    wdog_en = 1'b1; hb_auto = 1;
    rel_reset();
    tick(1);
    check("t1.e1.state", st_a, 0);
    check("t6.e1.state_b", st_b, 0);
    tick(1);
    check("t1.e2.state", st_a, 1);
    check("t6.e2.state_b", st_b, 2);
    check("t6.e2.rst_done_b", done_b, 1);
    tick(3);
    check("t1.e5.rst_sync_n", rsn_a, 0);
    tick(1);
    check("t1.e6.state", st_a, 2);
    check("t1.e6.rst_sync_n", rsn_a, 1);
    check("t1.e6.rst_done", done_a, 1);
    tick(1);
    check("t1.e7.rst_done", done_a, 0);
    tick(9);
    check("t1.e16.cycle_cnt", cnt_a, 10);

    // 2: one-cycle polarity glitch in RUN
    reset_n_obs = 1'b0;
    tick(1);
    reset_n_obs = 1'b1;
    check("t2.polarity_err", pe_a, 1);
    check("t2.running", run_a, 1);
    check("t2.cycle_cnt", cnt_a, 11);
    tick(5);
    check("t2.polarity_sticky", pe_a, 1);
    check("t6.cnt_b_sat", cnt_b, 15);
    do_reset();
    check("t2.polarity_clr", pe_a, 0);

    // 3: no heartbeat -> FAULT on the 16th RUN edge
    hb_auto = 0; hb_man = 0;
    rel_reset();
    tick(6 + 15);
    check("t3.pre.state", st_a, 2);
    tick(1);
    check("t3.state", st_a, 3);
    check("t3.rst_sync_n", rsn_a, 0);
    check("t3.wdog_fault", wf_a, 1);
    check("t3.cycle_cnt", cnt_a, 16);
    hb_auto = 1;
    tick(8);
    check("t3.hold.state", st_a, 3);
    check("t3.hold.cycle_cnt", cnt_a, 16);
    do_reset();

    // 4: heartbeat on the terminal edge rescues, then 16 quiet edges fault
    hb_auto = 0; hb_man = 0;
    rel_reset();
    tick(6 + 15);
    hb_man = 1;
    tick(1);
    hb_man = 0;
    check("t4.rescue.state", st_a, 2);
    tick(15);
    check("t4.pre.state", st_a, 2);
    tick(1);
    check("t4.fault.state", st_a, 3);
    check("t4.fault.cycle_cnt", cnt_a, 32);
    do_reset();
    wdog_en = 1'b0;
    rel_reset();
    tick(6 + 100);
    check("t4.dis.state", st_a, 2);
    check("t4.dis.wdog_fault", wf_a, 0);
    check("t4.dis.cycle_cnt", cnt_a, 100);
    do_reset();

    // 5: reset pulsed mid-STRETCH
    wdog_en = 1'b1; hb_auto = 1;
    rel_reset();
    tick(4);
    check("t5.mid.state", st_a, 1);
    reset = 1'b1; reset_n_obs = 1'b0;
    #1;
    check("t5.async.state", st_a, 0);
    check("t5.async.rst_sync_n", rsn_a, 0);
    check("t5.async.running_b", run_b, 0);
    check("t5.async.cycle_cnt_b", cnt_b, 0);
    tick(2);
    rel_reset();
    tick(5);
    check("t5.e5.rst_sync_n", rsn_a, 0);
    tick(1);
    check("t5.e6.rst_sync_n", rsn_a, 1);
    check("t5.e6.rst_done", done_a, 1);

    // reset on the RUN entry edge: rst_done never seen
    do_reset();
    rel_reset();
    tick(5);
    reset = 1'b1; reset_n_obs = 1'b0;
    tick(1);
    check("edge.rst_done", done_a, 0);
    check("edge.state", st_a, 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
